// File: rtl/alu_multicycle.sv
// Multi-cycle ALU execute stage: logic/arith ops finish in one EXEC cycle, while shifts
// move one bit position per cycle through an accumulator. Results are held in DONE until taken.
module alu_multicycle #(
  parameter int unsigned N = 32,
  parameter int unsigned S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         overflow,
  output logic         zero
);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpXor  = 4'b0010;
  localparam logic [3:0] OpNor  = 4'b0011;
  localparam logic [3:0] OpAdd  = 4'b0100;
  localparam logic [3:0] OpSub  = 4'b0101;
  localparam logic [3:0] OpSlt  = 4'b0110;
  localparam logic [3:0] OpSltu = 4'b0111;
  localparam logic [3:0] OpSll  = 4'b1000;
  localparam logic [3:0] OpSrl  = 4'b1001;
  localparam logic [3:0] OpSra  = 4'b1010;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e         state_q, state_d;
  logic [3:0]     op_q, op_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [S-1:0]   cnt_q, cnt_d;
  logic [N-1:0]   res_q, res_d;
  logic           ovf_q, ovf_d;
  logic           zero_q, zero_d;

  logic [N-1:0]   sum, diff, alu_res, acc_shift;
  logic           alu_ovf, is_shift;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = res_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

  assign sum      = a_q + b_q;
  assign diff     = a_q - b_q;
  assign is_shift = (op_q == OpSll) || (op_q == OpSrl) || (op_q == OpSra);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (op_q)
      OpAnd:  alu_res = a_q & b_q;
      OpOr:   alu_res = a_q | b_q;
      OpXor:  alu_res = a_q ^ b_q;
      OpNor:  alu_res = ~(a_q | b_q);
      OpAdd: begin
        alu_res = sum;
        alu_ovf = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
      end
      OpSub: begin
        alu_res = diff;
        alu_ovf = (a_q[N-1] != b_q[N-1]) && (diff[N-1] != a_q[N-1]);
      end
      // Direct signed compare stays correct when a - b would overflow.
      OpSlt:  alu_res = {{(N-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      OpSltu: alu_res = {{(N-1){1'b0}}, a_q < b_q};
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  always_comb begin
    acc_shift = acc_q;
    if (op_q == OpSll) begin
      acc_shift = {acc_q[N-2:0], 1'b0};
    end else if (op_q == OpSrl) begin
      acc_shift = {1'b0, acc_q[N-1:1]};
    end else if (op_q == OpSra) begin
      acc_shift = {acc_q[N-1], acc_q[N-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          acc_d   = a;
          cnt_d   = b[S-1:0];
          state_d = StExec;
        end
      end
      StExec: begin
        if (is_shift && (cnt_q != '0)) begin
          acc_d = acc_shift;
          cnt_d = cnt_q - S'(1);
        end else begin
          res_d   = is_shift ? acc_q : alu_res;
          ovf_d   = is_shift ? 1'b0 : alu_ovf;
          zero_d  = is_shift ? (acc_q == '0) : (alu_res == '0);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: a cycle-level transaction model checked every cycle, plus
// directed vectors with literal expected results and latencies.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        zero;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  alu_multicycle #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the op definitions.
  function automatic logic [31:0] f_res(input logic [3:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    case (o)
      4'd0:    return x & y;
      4'd1:    return x | y;
      4'd2:    return x ^ y;
      4'd3:    return ~(x | y);
      4'd4:    return x + y;
      4'd5:    return x - y;
      4'd6:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd7:    return (x < y) ? 32'd1 : 32'd0;
      4'd8:    return x << y[4:0];
      4'd9:    return x >> y[4:0];
      4'd10:   return 32'($signed(x) >>> y[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic f_ovf(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint s;
    if (o == 4'd4) s = longint'($signed(x)) + longint'($signed(y));
    else if (o == 4'd5) s = longint'($signed(x)) - longint'($signed(y));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic int f_lat(input logic [3:0] o, input logic [31:0] y);
    return (o >= 4'd8 && o <= 4'd10) ? int'(y[4:0]) + 1 : 1;
  endfunction

  // Transaction model: idle / busy for a countdown / done until taken.
  logic        m_busy, m_done, m_ovf, m_zero, p_ovf, p_zero;
  logic [31:0] m_res, p_res;
  int          m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_ovf  <= 1'b0;
      m_zero <= 1'b0;
      m_cnt  <= 0;
    end else if (m_done) begin
      if (out_ready) m_done <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_res  <= p_res;
        m_ovf  <= p_ovf;
        m_zero <= p_zero;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (in_valid) begin
      m_busy <= 1'b1;
      m_cnt  <= f_lat(op, b);
      p_res  <= f_res(op, a, b);
      p_ovf  <= f_ovf(op, a, b);
      p_zero <= (f_res(op, a, b) == 32'd0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, !(m_busy || m_done)});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_done});
      chk("result", result, m_res);
      chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
      chk("zero", {31'b0, zero}, {31'b0, m_zero});
    end
  end

  // One complete operation with literal expectations; operands are scrambled after accept.
  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] e_res, input logic e_ovf,
                        input logic e_zero, input int e_lat);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; op = ~o; a = ~x; b = y ^ 32'h5A5A_A5A5;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(e_lat));
    chk({name, "_result"}, result, e_res);
    chk({name, "_overflow"}, {31'b0, overflow}, {31'b0, e_ovf});
    chk({name, "_zero"}, {31'b0, zero}, {31'b0, e_zero});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;
    chk_en = 1'b1;

    run_op("slt_neg",  4'd6,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1);
    run_op("sub_ovf",  4'd5,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1);
    run_op("add_zero", 4'd4,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1);
    run_op("add_ovf",  4'd4,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, 1);
    run_op("sltu",     4'd7,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1);
    run_op("slt_pos",  4'd6,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1);
    run_op("and",      4'd0,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1);
    run_op("or",       4'd1,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1'b0, 1);
    run_op("xor",      4'd2,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 1'b0, 1);
    run_op("nor",      4'd3,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F, 1'b0, 1'b0, 1);
    run_op("illegal",  4'd15, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1);
    run_op("sra4",     4'd10, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0, 5);
    run_op("sll0",     4'd8,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0, 1);
    run_op("srl31",    4'd9,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, 32);
    run_op("sll3",     4'd8,  32'h8000_0003, 32'hFFFF_FFE3, 32'h0000_0018, 1'b0, 1'b0, 4);

    // Backpressure: result held and new request ignored until the handshake.
    @(posedge clk); #1;
    in_valid = 1'b1; op = 4'd4; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b1; op = 4'd5; a = 32'd100; b = 32'd1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_hold_result", result, 32'd11);
      chk("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_hold_out_valid", {31'b0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("bp_new_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_new_result", result, 32'd99);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during a long shift aborts it.
    @(posedge clk); #1;
    in_valid = 1'b1; op = 4'd8; a = 32'h0000_0001; b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (25) begin
      @(posedge clk); #1;
      chk("abort_no_valid", {31'b0, out_valid}, 32'd0);
    end
    run_op("add_after_rst", 4'd4, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Multi-cycle ALU execute stage that sits directly downstream of the operand/decode logic and consumes the structural compare, add and subtract primitives (slt, adderN).
- Accepts one operation at a time over a valid/ready handshake and registers the result.
- Computes shifts bit-serially, one bit position per cycle, so no barrel shifter is needed.
- Presents result, signed overflow and zero flags to the writeback stage over a second valid/ready handshake.

Parameters:
- N, 32, datapath width; must be a power of two, >= 2.
- S, $clog2(N), shift-amount width; the shift amount is taken from b[S-1:0].

Ports:
- clk  input  1  Single clock; all state updates on its rising edge.
- rst  input  1  Synchronous, active-high reset.
- in_valid  input  1  Operation request is valid.
- in_ready  output  1  Block can accept an operation.
- op  input  4  Operation code (see Behaviour).
- a  input  N  Operand A, two's complement.
- b  input  N  Operand B, two's complement; b[S-1:0] is the shift amount for shift ops.
- out_valid  output  1  result, overflow and zero are valid.
- out_ready  input  1  Consumer accepts the result.
- result  output  N  Operation result.
- overflow  output  1  Signed overflow; ADD/SUB only.
- zero  output  1  High when result == 0.

Behaviour:
- Op encoding:
  - 0000 AND, 0001 OR, 0010 XOR, 0011 NOR
  - 0100 ADD, 0101 SUB
  - 0110 SLT (signed), 0111 SLTU (unsigned)
  - 1000 SLL, 1001 SRL, 1010 SRA
  - Any other code: result = 0, overflow = 0, 1-cycle latency.
- FSM states: IDLE, EXEC, DONE.
- Reset (rst high at a clock edge):
  - state = IDLE.
  - out_valid = 0, result = 0, overflow = 0, zero = 0.
  - Shift counter and accumulator cleared.
  - Takes priority over every other event. Reset mid-operation aborts it; out_valid is never raised for the aborted op.
- in_ready = (state == IDLE). It is a combinational decode of the registered state, with no path from in_valid.
- IDLE:
  - On an edge with in_valid & in_ready: latch op, a, b; load accumulator = a; load counter = b[S-1:0]; go to EXEC.
- EXEC, non-shift op:
  - At the next edge, register result/overflow/zero, set out_valid = 1, go to DONE.
- EXEC, shift op:
  - If counter == 0: register accumulator as result, set out_valid = 1, go to DONE.
  - Else: shift accumulator by 1 (SLL fills 0; SRL fills 0 at MSB; SRA replicates MSB) and decrement counter.
- Latency from the accept edge to the edge that raises out_valid:
  - 1 cycle for non-shift ops.
  - shamt + 1 cycles for shifts (shamt = 0 gives 1 cycle).
- DONE:
  - out_valid = 1; result, overflow and zero are held stable while out_ready = 0.
  - On an edge with out_valid & out_ready: out_valid = 0, go to IDLE. in_ready rises in the following cycle; no same-cycle turnaround.
- Arithmetic rules:
  - ADD/SUB are N-bit with wrap-around.
  - overflow = operand signs compatible with overflow and result sign differs (SUB uses ~b + 1).
  - SLT must be correct even when a - b overflows: result = {N-1 zeros, a <s b}.
  - SLTU: result = {N-1 zeros, a <u b}.
  - overflow = 0 for all non-ADD/SUB ops.
- Boundaries:
  - in_valid while busy is ignored and not queued; the upstream stage holds its request.
  - op/a/b changes after the accept edge have no effect on the operation in flight.
  - Back-to-back operations each take at least 3 edges (accept, EXEC, handshake).

Test Plan:
- SLT, a=0x80000000, b=0x00000001 -> result=0x00000001, overflow=0, zero=0, out_valid rises exactly 1 edge after accept.
- SUB, a=0x7FFFFFFF, b=0xFFFFFFFF -> result=0x80000000, overflow=1. Then ADD, a=0xFFFFFFFF, b=0x00000001 -> result=0, zero=1, overflow=0.
- SLTU, a=0x00000001, b=0xFFFFFFFF -> result=1. SLT with the same operands -> result=0, zero=1.
- SRA, a=0x80000000, b=4 -> result=0xF8000000 with out_valid at accept+5 and in_ready=0 throughout. SLL with b=0 -> result=a at accept+1. SRL, a=0x80000000, b=31 -> result=0x00000001 at accept+32.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid while driving in_valid=1 with new operands -> result stable, in_ready=0, new op not accepted. Release out_ready -> in_ready=1 the next cycle; new op accepted on a later edge.
- Reset mid-op: SLL with b=20, assert rst at accept+5 for 1 cycle -> out_valid never asserts, all outputs 0, in_ready=1 the cycle after rst deasserts; the next ADD 2+3 completes with result=5.
